cpu_step_sequencer: RTL and testbench
=====================================

Name: cpu_step_sequencer

Overview:
Top-level control sequencer for the unpipelined processor. Runs each instruction through fixed phases: fetch, decode, execute, optional memory, writeback and PC update. Drives the program counter's load enable and the instruction-register, memory and register-file strobes. Supports single-step from a push button or free-run, and issues the second PC load that the PC register requires after a jump or branch.

Parameters:
MEM_WAIT, 1, cycles MemEn is held in the MEM phase; legal range 1..15.
CNT_W, 16, width of the retired-instruction counter.

Ports:
Clk  input  1  system clock
Rst  input  1  reset, synchronous, active-low
Step  input  1  single-step button, already debounced, synchronous level
Run  input  1  1 = free-run; 0 = one instruction per Step rising edge
Jump  input  1  decoder: current instruction is a jump
Branch  input  1  decoder: current instruction is a taken branch
MemRead  input  1  decoder: load instruction
MemWrite  input  1  decoder: store instruction
RegWriteReq  input  1  decoder: instruction writes the register file
Halt  input  1  decoder: halt instruction
PcEn  output  1  PC load enable
IrLoad  output  1  instruction register load strobe
MemEn  output  1  data memory access enable
RegWe  output  1  register file write enable
Busy  output  1  an instruction is in progress
Halted  output  1  sequencer is stopped on a halt instruction
InstrCount  output  CNT_W  retired-instruction count

Behaviour:
- Reset (Rst=0 at a Clk edge) has these effects:
  - state goes to IDLE;
  - PcEn, IrLoad, MemEn, RegWe, Busy, Halted and InstrCount all go to 0;
  - the Step history register goes to 0.
- Reset takes priority in any state and aborts an instruction mid-phase with no strobe issued on the following cycle.
- StepPulse = Step & ~Step_q, where Step_q is Step registered once.
- Strobes are Moore outputs decoded from the registered state. Each strobe lasts exactly one cycle unless stated otherwise.
- State transitions:
  - IDLE: if Run=1 or StepPulse=1, go to FETCH; otherwise stay.
  - FETCH: IrLoad=1; go to DECODE.
  - DECODE: if Halt=1, go to HALTED; otherwise go to EXEC.
  - EXEC: if MemRead or MemWrite, go to MEM; otherwise go to WB.
  - MEM: MemEn=1 for MEM_WAIT consecutive cycles, timed by a 4-bit wait counter loaded on entry; then go to WB.
  - WB: RegWe = RegWriteReq; go to PCUPD.
  - PCUPD: PcEn=1. If Jump or Branch, go to REDIRECT; otherwise go to IDLE and increment InstrCount.
  - REDIRECT: PcEn=1 again, to reload the target address; go to IDLE and increment InstrCount.
  - HALTED: Halted=1; all strobes stay 0; the only exit is reset.
- Busy=1 in every state except IDLE and HALTED.
- Latency from start to return to IDLE:
  - non-memory, non-jump instruction: 5 cycles;
  - memory access adds MEM_WAIT cycles;
  - jump/branch adds 1 cycle.
- Decoder inputs are stable from DECODE through REDIRECT. Each is sampled only in the state that uses it.
- A Step edge arriving while Busy=1 is discarded, not queued.
- Run falling mid-instruction: the instruction completes, then the sequencer waits in IDLE.
- Run=1 continuously: IDLE lasts exactly 1 cycle between instructions.
- InstrCount wraps from 2^CNT_W-1 to 0. The halt instruction is not counted.

Optional Feature:
SEQ_BREAKPOINT_EN
- Defined: adds these ports:
  - inputs BpValid (1) and BpAddr (32);
  - input PcValue (32), the current PC;
  - output BpHit (1).
- In IDLE with Run=1, BpValid=1 and PcValue==BpAddr, auto-start is suppressed and BpHit=1.
- While BpHit=1, a StepPulse executes exactly one instruction. The breakpoint then re-arms for the next match.
- Undefined: these ports are absent and Run always auto-starts.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, REDIRECT, HALTED;
  - the default MEM_WAIT;
  - the wait-counter width constant (4).
- One sub-module, step_edge_detect: holds the Step history register and produces StepPulse. It is reused by other button-driven blocks.

Test Plan:
- Reset with Run=0, then Step held low for 20 cycles -> state stays IDLE; all strobes 0; InstrCount=0.
- One Step edge with an ALU instruction (RegWriteReq=1, no jump or memory) -> IrLoad at cycle 1 after start and RegWe at cycle 4. PcEn fires exactly once at cycle 5. InstrCount=1 and Busy falls.
- Run=1 with Jump=1 -> PcEn high in two consecutive cycles (PCUPD then REDIRECT); 6 cycles per instruction.
- MEM_WAIT=3 with MemRead=1 -> MemEn high for exactly 3 cycles, then RegWe, then PcEn; instruction takes 8 cycles.
- Halt=1 at DECODE -> Halted=1; no PcEn ever; Step edges ignored; Rst=0 returns to IDLE.
- Step edge while Busy=1, and Rst=0 during MEM -> no extra instruction starts; reset clears all outputs on the next edge. Also preload InstrCount=16'hFFFF, retire one instruction -> InstrCount=0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the unpipelined CPU step sequencer.
package cpu_seq_pkg;

  localparam int SEQ_MEM_WAIT_DEFAULT = 1;
  localparam int SEQ_WAIT_W           = 4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC     = 4'd3,
    MEM      = 4'd4,
    WB       = 4'd5,
    PCUPD    = 4'd6,
    REDIRECT = 4'd7,
    HALTED   = 4'd8
  } seq_state_t;

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for an already-debounced, synchronous push button.
module step_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic Step,
  output logic StepPulse
);

  logic step_reg;

  always_ff @(posedge Clk) begin
    if (!Rst) step_reg <= 1'b0;
    else      step_reg <= Step;
  end

  assign StepPulse = Step & ~step_reg;

endmodule

// File: rtl/cpu_step_sequencer.sv
// Phase sequencer for the unpipelined CPU: fetch/decode/exec/mem/wb/pc-update.
// Optional breakpoint ports and logic are compiled in with SEQ_BREAKPOINT_EN.
module cpu_step_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_WAIT = SEQ_MEM_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Step,
  input  logic             Run,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegWriteReq,
  input  logic             Halt,
  output logic             PcEn,
  output logic             IrLoad,
  output logic             MemEn,
  output logic             RegWe,
  output logic             Busy,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic             BpValid,
  input  logic [31:0]      BpAddr,
  input  logic [31:0]      PcValue,
  output logic             BpHit
`endif
);

  seq_state_t              state_reg, state_next;
  logic [SEQ_WAIT_W-1:0]   wait_reg, wait_next;
  logic [CNT_W-1:0]        count_reg;
  logic                    step_pulse;
  logic                    start;
  logic                    retire;

  step_edge_detect u_step_edge (
    .Clk       (Clk),
    .Rst       (Rst),
    .Step      (Step),
    .StepPulse (step_pulse)
  );

`ifdef SEQ_BREAKPOINT_EN
  logic bp_match;
  // A matching PC holds off free-run; only a Step press moves past it.
  assign bp_match = BpValid && (PcValue == BpAddr);
  assign BpHit    = (state_reg == IDLE) && Run && bp_match;
  assign start    = step_pulse | (Run & ~bp_match);
`else
  assign start    = Run | step_pulse;
`endif

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    unique case (state_reg)
      IDLE:     if (start) state_next = FETCH;
      FETCH:    state_next = DECODE;
      DECODE:   state_next = Halt ? HALTED : EXEC;
      EXEC: begin
        if (MemRead || MemWrite) begin
          state_next = MEM;
          wait_next  = SEQ_WAIT_W'(MEM_WAIT - 1);
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        if (wait_reg == '0) state_next = WB;
        else                wait_next  = wait_reg - SEQ_WAIT_W'(1);
      end
      WB:       state_next = PCUPD;
      PCUPD:    state_next = (Jump || Branch) ? REDIRECT : IDLE;
      REDIRECT: state_next = IDLE;
      HALTED:   state_next = HALTED;
      default:  state_next = IDLE;
    endcase
  end

  assign retire = ((state_reg == PCUPD) && !(Jump || Branch)) ||
                  (state_reg == REDIRECT);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign IrLoad     = (state_reg == FETCH);
  assign MemEn      = (state_reg == MEM);
  assign RegWe      = (state_reg == WB) && RegWriteReq;
  assign PcEn       = (state_reg == PCUPD) || (state_reg == REDIRECT);
  assign Busy       = (state_reg != IDLE) && (state_reg != HALTED);
  assign Halted     = (state_reg == HALTED);
  assign InstrCount = count_reg;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Randomized self-checking bench for cpu_step_sequencer against a per-cycle strobe model.
module tb_cpu_step_sequencer;

  localparam int MW = 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, Step, Run, Jump, Branch, MemRead, MemWrite, RegWriteReq, Halt;
  logic PcEn, IrLoad, MemEn, RegWe, Busy, Halted;
  logic [15:0] InstrCount;

  logic Step2, Run2;
  logic PcEn2, IrLoad2, MemEn2, RegWe2, Busy2, Halted2;
  logic [2:0] InstrCount2;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_count;

  cpu_step_sequencer #(.MEM_WAIT(MW), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Run(Run), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWriteReq(RegWriteReq), .Halt(Halt),
    .PcEn(PcEn), .IrLoad(IrLoad), .MemEn(MemEn), .RegWe(RegWe), .Busy(Busy),
    .Halted(Halted), .InstrCount(InstrCount)
  );

  // Narrow counter instance so counter wrap is reachable in a short run.
  cpu_step_sequencer #(.MEM_WAIT(1), .CNT_W(3)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .Step(Step2), .Run(Run2), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWriteReq(RegWriteReq), .Halt(Halt),
    .PcEn(PcEn2), .IrLoad(IrLoad2), .MemEn(MemEn2), .RegWe(RegWe2), .Busy(Busy2),
    .Halted(Halted2), .InstrCount(InstrCount2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {IrLoad, MemEn, RegWe, PcEn, Busy, Halted};
  endfunction

  // Expected {IrLoad,MemEn,RegWe,PcEn,Busy,Halted} on cycle c (1-based) after start.
  function automatic logic [5:0] model_outs(int c, bit mem, bit wr, bit br);
    int  mc = mem ? MW : 0;
    int  wb = 4 + mc;
    bit  ir = (c == 1);
    bit  me = mem && (c >= 4) && (c < 4 + mc);
    bit  we = wr && (c == wb);
    bit  pc = (c == wb + 1) || (br && (c == wb + 2));
    return {ir, me, we, pc, 1'b1, 1'b0};
  endfunction

  // Entered and left on a negedge with the DUT in IDLE.
  task automatic do_instr(input bit mem, input bit rd, input bit wr, input int brsel,
                          input bit step_mode, input bit poke, input bit stay_run);
    bit br = (brsel != 0);
    int len = 5 + (mem ? MW : 0) + (br ? 1 : 0);
    MemRead = mem & rd;  MemWrite = mem & ~rd;  RegWriteReq = wr;
    Jump = (brsel == 1); Branch = (brsel == 2); Halt = 1'b0;
    if (step_mode) Step = 1'b1; else Run = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge Clk);
      if (step_mode) begin
        if (c == 1) Step = 1'b0;
        if (poke && c == 2) Step = 1'b1;
        if (c == 3) Step = 1'b0;
      end
      check($sformatf("cyc%0d m%0d w%0d b%0d", c, mem, wr, brsel), 32'(dut_outs()),
            32'(model_outs(c, mem, wr, br)));
      if (c == len && !stay_run) Run = 1'b0;
    end
    @(negedge Clk);
    exp_count++;
    check("idle_outs", 32'(dut_outs()), 32'd0);
    check("count", 32'(InstrCount), 32'(exp_count));
    $display("instr mem=%0d wr=%0d br=%0d step=%0d len=%0d count=%0d",
             mem, wr, brsel, step_mode, len, InstrCount);
  endtask

  initial begin
    Rst = 1'b0; Step = 1'b0; Run = 1'b0; Jump = 1'b0; Branch = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWriteReq = 1'b0; Halt = 1'b0;
    Step2 = 1'b0; Run2 = 1'b0; exp_count = '0;
    repeat (3) @(negedge Clk);
    check("reset_outs", 32'(dut_outs()), 32'd0);
    check("reset_count", 32'(InstrCount), 32'd0);
    Rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("idle_hold", 32'({dut_outs(), InstrCount}), 32'd0);
    end

    do_instr(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);   // ALU, single step
    do_instr(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);   // jump, free-run
    do_instr(1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);   // load, MEM_WAIT cycles

    for (int i = 0; i < 20; i++)
      do_instr(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
               int'($urandom % 3), 1'b1, 1'($urandom % 2), 1'b0);
    for (int i = 0; i < 12; i++)
      do_instr(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
               int'($urandom % 3), 1'b0, 1'b0, (i != 11));

    // Halt: stuck in HALTED until reset, ignoring Step and Run.
    Halt = 1'b1; Step = 1'b1;
    @(negedge Clk); Step = 1'b0;
    check("halt_fetch", 32'(dut_outs()), 32'b100010);
    @(negedge Clk);
    check("halt_decode", 32'(dut_outs()), 32'b000010);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      Step = 1'(i % 2); Run = 1'(i > 5);
      check("halted", 32'(dut_outs()), 32'b000001);
      check("halt_count", 32'(InstrCount), 32'(exp_count));
    end
    Rst = 1'b0; Run = 1'b0; Step = 1'b0;
    @(negedge Clk);
    exp_count = '0;
    check("halt_reset", 32'({dut_outs(), InstrCount}), 32'd0);
    Rst = 1'b1; Halt = 1'b0;
    $display("halt sequence done");

    // Reset during MEM aborts the instruction with no strobe afterwards.
    MemRead = 1'b1; MemWrite = 1'b0; RegWriteReq = 1'b1; Jump = 1'b0; Branch = 1'b0;
    Step = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (c == 1) Step = 1'b0;
      if (c == 2) Step = 1'b1;
      if (c == 3) Step = 1'b0;
      check("pre_abort", 32'(dut_outs()), 32'(model_outs(c, 1'b1, 1'b1, 1'b0)));
    end
    Rst = 1'b0;
    @(negedge Clk);
    check("abort_reset", 32'({dut_outs(), InstrCount}), 32'd0);
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("abort_idle", 32'({dut_outs(), InstrCount}), 32'd0);
    end
    $display("mem abort done");

    // Wrap of the 3-bit counter on the narrow instance.
    MemRead = 1'b0; RegWriteReq = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      Step2 = 1'b1;
      @(negedge Clk); Step2 = 1'b0;
      repeat (6) @(negedge Clk);
      check($sformatf("wrap%0d", i), 32'({Busy2, InstrCount2}), 32'(i % 8));
      $display("wrap instr %0d count=%0d", i, InstrCount2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
